// File: rtl/panda_pkg.sv
`default_nettype none
// ============================================================================
// Module      : panda_pkg
// Description : Shared types for the PANDA core memory-side blocks. Holds the
//               arbiter FSM state and owner encodings plus a small helper
//               for the saturating starvation counter.
// Revision    : 1.0 - initial release
// ============================================================================
package panda_pkg;

    // Arbiter FSM: IDLE = nothing outstanding, WAIT = one response pending.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    // Which requester owns the in-flight (or locked) memory request.
    typedef enum logic [0:0] {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } arb_owner_e;

    localparam int unsigned STARVE_W = 4;

    // Increment that sticks at the given ceiling.
    function automatic logic [STARVE_W-1:0] sat_inc(
        input logic [STARVE_W-1:0] value,
        input logic [STARVE_W-1:0] ceiling
    );
        return (value >= ceiling) ? ceiling : value + 4'd1;
    endfunction

endpackage : panda_pkg
`default_nettype wire

// File: rtl/panda_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : panda_mem_arbiter
// Description : Two-requester arbiter (instruction fetch / load-store) in
//               front of a single-port memory. One transaction in flight at
//               a time. Data wins by default; instruction fetch is promoted
//               once it has watched STARVE_LIMIT data grants go by.
// Ports       : clk_i, rst_i               - clock, synchronous active-high reset
//               instr_req/addr_i           - fetch request in
//               instr_gnt/rvalid/rdata_o   - fetch handshake/response out
//               data_req/addr/we/wdata_i   - load/store request in
//               data_gnt/rvalid/rdata_o    - load/store handshake/response out
//               mem_req/addr/we/wdata_o    - shared memory request out
//               mem_gnt/rvalid/rdata_i     - shared memory handshake/response in
// Revision    : 1.0 - initial release
// ============================================================================
module panda_mem_arbiter
    import panda_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_we_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic                lock_q, lock_d;
    arb_owner_e          lock_owner_q, lock_owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    arb_owner_e sel;
    logic       sel_req;
    logic       idle_active;
    logic       grant;
    logic       resp;

    // ------------------------------------------------------------------
    // Requester selection. A request that was presented but not yet
    // granted keeps the bus: otherwise the address could change under a
    // memory that is part-way through accepting it.
    // ------------------------------------------------------------------
    always_comb begin
        sel     = OWNER_INSTR;
        sel_req = instr_req_i;
        if (lock_q) begin
            sel     = lock_owner_q;
            sel_req = (lock_owner_q == OWNER_DATA) ? data_req_i : instr_req_i;
        end else if (data_req_i && !((starve_q == STARVE_MAX) && instr_req_i)) begin
            sel     = OWNER_DATA;
            sel_req = 1'b1;
        end
    end

    // Reset gates the outputs directly so nothing leaks out during the
    // reset cycle even though the state registers update on the edge.
    assign idle_active = !rst_i && (state_q == ARB_IDLE);
    assign resp        = !rst_i && (state_q == ARB_WAIT) && mem_rvalid_i;

    assign mem_req_o   = idle_active && sel_req;
    assign grant       = mem_req_o && mem_gnt_i;

    assign mem_addr_o  = (sel == OWNER_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = (sel == OWNER_DATA) ? data_we_i    : 4'b0000;
    assign mem_wdata_o = (sel == OWNER_DATA) ? data_wdata_i : 32'd0;

    assign instr_gnt_o = grant && (sel == OWNER_INSTR);
    assign data_gnt_o  = grant && (sel == OWNER_DATA);

    // Response is steered by owner only; read data is broadcast.
    assign instr_rvalid_o = resp && (owner_q == OWNER_INSTR);
    assign data_rvalid_o  = resp && (owner_q == OWNER_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        starve_d     = starve_q;

        case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    state_d = ARB_WAIT;
                    owner_d = sel;
                    lock_d  = 1'b0;
                    if (sel == OWNER_INSTR) begin
                        starve_d = '0;
                    end else if (instr_req_i) begin
                        starve_d = sat_inc(starve_q, STARVE_MAX);
                    end
                end else if (mem_req_o) begin
                    lock_d       = 1'b1;
                    lock_owner_d = sel;
                end else begin
                    lock_d = 1'b0;
                end
            end
            ARB_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_INSTR;
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INSTR;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            starve_q     <= starve_d;
        end
    end

endmodule : panda_mem_arbiter
`default_nettype wire

// File: tb/tb_panda_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_panda_mem_arbiter
// Description : Self-checking bench for panda_mem_arbiter. A reference model
//               of the arbitration rules predicts the memory-side request and
//               grants every cycle; granted transactions are queued and popped
//               by a response monitor whenever the DUT raises an rvalid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_panda_mem_arbiter;
    import panda_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, data_req;
    logic [31:0] instr_addr, data_addr, data_wdata;
    logic [3:0]  data_we;
    logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid;
    logic [31:0] instr_rdata, data_rdata;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    always #5 clk = ~clk;

    panda_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
        .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_rdata_o(data_rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state (0 = instr, 1 = data) -------------
    bit m_busy, m_owner, m_lock, m_lock_owner;
    int m_starve;
    bit g_instr, g_data;         // model grant at the upcoming edge
    bit e_sel, e_sreq, e_req, e_gnt, e_rv;
    int exp_q[$];                // owner of each granted transaction
    int order_q[$];              // observed grant order for the fairness test
    bit rec_order = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outputs", 32'({mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid}), 32'd0);
            m_busy = 0; m_owner = 0; m_lock = 0; m_lock_owner = 0; m_starve = 0;
            g_instr = 0; g_data = 0;
            exp_q.delete();
        end else begin
            if (m_lock) begin
                e_sel  = m_lock_owner;
                e_sreq = e_sel ? data_req : instr_req;
            end else if (data_req && !(m_starve == LIMIT && instr_req)) begin
                e_sel  = 1'b1;
                e_sreq = 1'b1;
            end else begin
                e_sel  = 1'b0;
                e_sreq = instr_req;
            end
            e_req = !m_busy && e_sreq;
            e_gnt = e_req && mem_gnt;
            e_rv  = m_busy && mem_rvalid;

            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("instr_gnt", 32'(instr_gnt), 32'(e_gnt && !e_sel));
            chk("data_gnt", 32'(data_gnt), 32'(e_gnt && e_sel));
            if (e_req) begin
                chk("mem_addr", mem_addr, e_sel ? data_addr : instr_addr);
                chk("mem_we", 32'(mem_we), e_sel ? 32'(data_we) : 32'd0);
                chk("mem_wdata", mem_wdata, e_sel ? data_wdata : 32'd0);
            end
            chk("instr_rvalid", 32'(instr_rvalid), 32'(e_rv && !m_owner));
            chk("data_rvalid", 32'(data_rvalid), 32'(e_rv && m_owner));

            if (rec_order && (instr_gnt || data_gnt)) order_q.push_back(data_gnt ? 1 : 0);

            g_instr = e_gnt && !e_sel;
            g_data  = e_gnt && e_sel;
            if (e_rv) m_busy = 0;
            if (e_gnt) begin
                m_busy  = 1;
                m_owner = e_sel;
                m_lock  = 0;
                if (!e_sel) m_starve = 0;
                else if (instr_req && m_starve < LIMIT) m_starve++;
                exp_q.push_back(int'(e_sel));
            end else if (e_req) begin
                m_lock       = 1;
                m_lock_owner = e_sel;
            end else begin
                m_lock = 0;
            end
        end
    end

    // ---------------- response monitor ----------------------------------------
    int got_owner;
    always @(negedge clk) begin
        if (!rst && (instr_rvalid || data_rvalid)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected actual=instr:%b data:%b required=no rvalid t=%0t",
                         instr_rvalid, data_rvalid, $time);
            end else begin
                got_owner = exp_q.pop_front();
                chk("resp_owner", 32'(data_rvalid), 32'(got_owner));
                chk("resp_both", 32'(instr_rvalid && data_rvalid), 32'd0);
                chk("instr_rdata", instr_rdata, mem_rdata);
                chk("data_rdata", data_rdata, mem_rdata);
            end
        end
    end

    // ---------------- stimulus -------------------------------------------------
    bit auto_resp = 1'b1;
    int lat_fix   = 0;
    int resp_cnt  = 0;

    // Advance one cycle; the memory responder runs here.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        if (rst) begin
            resp_cnt = 0;
        end else begin
            if (g_instr || g_data) resp_cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
            if (auto_resp && resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                end
            end
        end
    endtask

    task automatic drop_granted();
        if (g_instr) instr_req = 1'b0;
        if (g_data)  data_req  = 1'b0;
    endtask

    task automatic settle();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            drop_granted();
            done = !instr_req && !data_req && !m_busy && resp_cnt == 0;
        end
        chk("settle_timeout", 32'(done), 32'd1);
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    int exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int guard;

    initial begin
        rst = 1'b1;
        instr_req = 0; instr_addr = 0;
        data_req = 0; data_addr = 0; data_we = 0; data_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        tick(); tick();
        rst = 1'b0;

        // Both request in IDLE: data wins, response 2 cycles later to data only.
        instr_req = 1; instr_addr = 32'h40;
        data_req = 1; data_addr = 32'h80; data_we = 4'hF; data_wdata = 32'h1234_5678;
        mem_gnt = 1; lat_fix = 2;
        at_sample();
        chk("both_data_gnt", 32'(data_gnt), 32'd1);
        chk("both_instr_gnt", 32'(instr_gnt), 32'd0);
        chk("both_mem_we", 32'(mem_we), 32'hF);
        tick(); instr_req = 0; data_req = 0; mem_gnt = 0;
        tick();
        at_sample();
        chk("both_data_rvalid", 32'(data_rvalid), 32'd1);
        chk("both_instr_rvalid", 32'(instr_rvalid), 32'd0);
        settle();

        // Lock: instr pending without grant, data arrives later, instr still first.
        lat_fix = 1;
        instr_req = 1; instr_addr = 32'h200; mem_gnt = 0;
        at_sample(); chk("lock_addr_c1", mem_addr, 32'h200);
        tick();
        data_req = 1; data_addr = 32'h300; data_we = 0;
        at_sample(); chk("lock_addr_c2", mem_addr, 32'h200);
        tick();
        at_sample(); chk("lock_addr_c3", mem_addr, 32'h200);
        tick();
        mem_gnt = 1;
        at_sample();
        chk("lock_instr_first", 32'(instr_gnt), 32'd1);
        chk("lock_data_wait", 32'(data_gnt), 32'd0);
        settle();

        // Starvation promotion: both held continuously.
        order_q.delete();
        rec_order = 1;
        instr_req = 1; data_req = 1; mem_gnt = 1;
        guard = 0;
        while (order_q.size() < 10 && guard < 100) begin
            tick();
            if (g_instr) instr_addr = instr_addr + 4;
            if (g_data)  data_addr  = data_addr + 4;
            guard++;
        end
        rec_order = 0;
        chk("order_count_timeout", 32'(order_q.size() >= 10), 32'd1);
        for (int i = 0; i < 10; i++)
            chk($sformatf("order_%0d", i), (i < order_q.size()) ? 32'(order_q[i]) : 32'hFFFF_FFFF,
                32'(exp_order[i]));
        instr_req = 0; data_req = 0;
        settle();

        // Store passes through exactly; rvalid is a single-cycle pulse.
        data_req = 1; data_addr = 32'h100; data_we = 4'b0011; data_wdata = 32'hDEAD_BEEF;
        mem_gnt = 1;
        at_sample();
        chk("store_req", 32'(mem_req), 32'd1);
        chk("store_addr", mem_addr, 32'h100);
        chk("store_we", 32'(mem_we), 32'h3);
        chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(); data_req = 0;
        at_sample(); chk("store_rvalid", 32'(data_rvalid), 32'd1);
        tick();
        at_sample(); chk("store_rvalid_pulse", 32'(data_rvalid), 32'd0);
        settle();

        // Stray response in IDLE is ignored.
        tick();
        mem_rvalid = 1; mem_rdata = 32'hBAD0_0001;
        at_sample();
        chk("idle_rv_instr", 32'(instr_rvalid), 32'd0);
        chk("idle_rv_data", 32'(data_rvalid), 32'd0);
        tick();
        data_req = 1; data_addr = 32'h44; data_we = 0; mem_gnt = 1;
        at_sample(); chk("idle_rv_still_idle", 32'(data_gnt), 32'd1);
        settle();

        // Reset while waiting; late response dropped; next request normal.
        auto_resp = 0;
        data_req = 1; data_addr = 32'h88; mem_gnt = 1;
        at_sample(); chk("rstw_gnt", 32'(data_gnt), 32'd1);
        tick(); data_req = 0;
        at_sample(); chk("rstw_wait_noreq", 32'(mem_req), 32'd0);
        tick(); rst = 1;
        tick(); rst = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0_0002;
        at_sample();
        chk("rstw_late_instr", 32'(instr_rvalid), 32'd0);
        chk("rstw_late_data", 32'(data_rvalid), 32'd0);
        tick();
        auto_resp = 1;
        instr_req = 1; instr_addr = 32'h500; mem_gnt = 1;
        at_sample(); chk("rstw_next_gnt", 32'(instr_gnt), 32'd1);
        settle();

        // Randomized traffic.
        lat_fix = 0;
        for (int c = 0; c < 800; c++) begin
            tick();
            drop_granted();
            if (!instr_req && $urandom_range(0, 99) < 45) begin
                instr_req  = 1;
                instr_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!data_req && $urandom_range(0, 99) < 45) begin
                data_req   = 1;
                data_addr  = $urandom;
                data_we    = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
                data_wdata = $urandom;
            end
            mem_gnt = ($urandom_range(0, 99) < 60);
            if (!m_busy && resp_cnt == 0 && !mem_rvalid && $urandom_range(0, 9) == 0) begin
                mem_rvalid = 1;
                mem_rdata  = $urandom;
            end
        end
        instr_req = 0; data_req = 0; mem_gnt = 1;
        settle();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_panda_mem_arbiter
`default_nettype wire

// File: doc/panda_mem_arbiter.md
PANDA_MEM_ARBITER -- requirements
Module: panda_mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive data grants while instr_req_i waits before instr gets priority (range 1..15).
REQ-002 clk_i  input  1  single clock, all state on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 instr_req_i  input  1  fetch request, held until granted.
REQ-005 instr_addr_i  input  32  fetch address.
REQ-006 instr_gnt_o  output  1  fetch request accepted this cycle.
REQ-007 instr_rvalid_o  output  1  fetch read data valid.
REQ-008 instr_rdata_o  output  32  fetch read data.
REQ-009 data_req_i  input  1  load/store request, held until granted.
REQ-010 data_addr_i  input  32  load/store address.
REQ-011 data_we_i  input  4  byte write enables; 0 = load.
REQ-012 data_wdata_i  input  32  store data.
REQ-013 data_gnt_o  output  1  load/store accepted this cycle.
REQ-014 data_rvalid_o  output  1  load data valid / store complete.
REQ-015 data_rdata_o  output  32  load data.
REQ-016 mem_req_o, mem_addr_o[31:0], mem_we_o[3:0], mem_wdata_o[31:0]  outputs  shared single-port memory request.
REQ-017 mem_gnt_i  input  1  memory accepts mem_req_o this cycle.
REQ-018 mem_rvalid_i, mem_rdata_i[31:0]  inputs  memory response, one per granted request (loads, stores and fetches).

Function
REQ-019 The block SHALL be an FSM with states IDLE (no outstanding) and WAIT (one outstanding), with at most one transaction in flight.
REQ-020 In IDLE with any request, the block SHALL drive mem_req_o=1 and the selected requester's addr/we/wdata combinationally; for instr, mem_we_o=0 and mem_wdata_o=0.
REQ-021 Selection SHALL be data over instr, unless starve_cnt==STARVE_LIMIT and instr_req_i=1, in which case instr SHALL be selected.
REQ-022 Once mem_req_o is asserted without mem_gnt_i, the selection SHALL be locked until that request is granted, even if the other requester asserts later.
REQ-023 The requester's gnt SHALL equal mem_gnt_i AND (selected); the other gnt SHALL be 0; on grant the owner SHALL be registered and the FSM SHALL move to WAIT.
REQ-024 In WAIT, mem_req_o and both gnt outputs SHALL be 0; a new request SHALL be issued no earlier than the cycle after mem_rvalid_i.
REQ-025 In WAIT, mem_rvalid_i SHALL be routed combinationally to the owner's rvalid, with zero added latency; the FSM SHALL then return to IDLE.
REQ-026 instr_rdata_o and data_rdata_o SHALL both equal mem_rdata_i; only rvalid is steered.
REQ-027 mem_rvalid_i in IDLE SHALL be ignored: no rvalid output, no state change.
REQ-028 starve_cnt (4 bit) SHALL increment, saturating at STARVE_LIMIT, on each data grant while instr_req_i=1; it SHALL clear on every instr grant.
REQ-029 A request granted in the same cycle the FSM leaves IDLE SHALL not be granted again; the requester SHALL deassert or present the next request.

Reset
REQ-030 While rst_i=1, the block SHALL enter IDLE, clear owner, lock and starve_cnt, and drive mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o and data_rvalid_o to 0.
REQ-031 A response pending at reset SHALL be dropped; a mem_rvalid_i arriving after reset SHALL be ignored as in REQ-027.

Structure
REQ-032 The owner/state enum (ARB_IDLE, ARB_WAIT; OWNER_INSTR, OWNER_DATA) SHALL be declared in panda_pkg.
REQ-033 The block SHALL be one flat module with no sub-modules; the core integrates it between panda_if_stage/panda_mem_stage and a single memory.

Verification
REQ-034 Bench: instr_req and data_req both asserted in IDLE, mem_gnt=1 -> data_gnt=1, instr_gnt=0, mem_we=data_we; with rvalid 2 cycles later -> data_rvalid=1 only.
REQ-035 Bench: instr_req pending, mem_gnt=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays instr_addr; instr is granted first.
REQ-036 Bench: STARVE_LIMIT=4, data_req and instr_req held continuously -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-037 Bench: store (data_we=4'b0011, addr=0x100, wdata=0xDEADBEEF) -> mem outputs match exactly; rvalid -> data_rvalid pulses for 1 cycle.
REQ-038 Bench: mem_rvalid_i=1 in IDLE -> both rvalid outputs stay 0, state stays IDLE.
REQ-039 Bench: rst_i pulsed in WAIT, late mem_rvalid_i next cycle -> no rvalid output; the next request is granted normally.
